// File: rtl/scan_window_ctrl.sv
// Sliding-window scan sequencer: streams the pixel addresses of each window to the
// frame buffer, waits for the classifier verdict and forwards positive windows as (x,y) detections.
module scan_window_ctrl #(
  parameter int IMG_WIDTH      = 320,
  parameter int IMG_HEIGHT     = 240,
  parameter int FEATURE_WIDTH  = 24,
  parameter int FEATURE_HEIGHT = 24,
  parameter int STEP           = 1,
  parameter int W_ADDR         = $clog2(IMG_WIDTH * IMG_HEIGHT),
  parameter int W_X            = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1,
  parameter int W_Y            = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [W_ADDR-1:0] addr_data,
  output logic [1:0]        addr_eot,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic              res_detect,
  output logic              det_valid,
  input  logic              det_ready,
  output logic [W_X-1:0]    det_x,
  output logic [W_Y-1:0]    det_y,
  output logic [2:0]        dbg_state
);

  // Every stream (addr, res, det) transfers a beat on a rising edge where valid and
  // ready are both high; the producer holds valid and payload steady until that edge.

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_DET  = 3'd3;
  localparam logic [2:0] S_NEXT = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam int W_XX = (FEATURE_WIDTH > 1) ? $clog2(FEATURE_WIDTH) : 1;
  localparam int W_YY = (FEATURE_HEIGHT > 1) ? $clog2(FEATURE_HEIGHT) : 1;

  localparam logic [W_XX-1:0]   XX_LAST = W_XX'(FEATURE_WIDTH - 1);
  localparam logic [W_YY-1:0]   YY_LAST = W_YY'(FEATURE_HEIGHT - 1);
  localparam logic [W_X-1:0]    X_LAST  = W_X'(((IMG_WIDTH - FEATURE_WIDTH) / STEP) * STEP);
  localparam logic [W_Y-1:0]    Y_LAST  = W_Y'(((IMG_HEIGHT - FEATURE_HEIGHT) / STEP) * STEP);
  localparam logic [W_X-1:0]    X_STEP  = W_X'(STEP);
  localparam logic [W_Y-1:0]    Y_STEP  = W_Y'(STEP);
  localparam logic [W_ADDR-1:0] ROW_INC = W_ADDR'(IMG_WIDTH);
  localparam logic [W_ADDR-1:0] X_INC   = W_ADDR'(STEP);
  localparam logic [W_ADDR-1:0] Y_INC   = W_ADDR'(STEP * IMG_WIDTH);

  if (IMG_WIDTH < FEATURE_WIDTH || IMG_HEIGHT < FEATURE_HEIGHT || STEP < 1) begin : g_param_check
    $error("scan_window_ctrl: window larger than frame or STEP < 1");
  end

  logic [2:0]        state_q, state_d;
  logic [W_XX-1:0]   xx_q, xx_d;
  logic [W_YY-1:0]   yy_q, yy_d;
  logic [W_X-1:0]    x_off_q, x_off_d;
  logic [W_Y-1:0]    y_off_q, y_off_d;
  logic [W_ADDR-1:0] addr_q, addr_d;
  logic [W_ADDR-1:0] row_base_q, row_base_d;
  logic [W_ADDR-1:0] win_base_q, win_base_d;
  logic [W_ADDR-1:0] line_base_q, line_base_d;

  logic pix_fire;
  logic row_end;
  logic win_end;
  logic x_last;
  logic y_last;

  assign pix_fire = addr_valid & addr_ready;
  assign row_end  = (xx_q == XX_LAST);
  assign win_end  = row_end & (yy_q == YY_LAST);
  assign x_last   = (x_off_q == X_LAST);
  assign y_last   = (y_off_q == Y_LAST);

  // Addresses are built by adding, never multiplying: line_base = y_off*W,
  // win_base = line_base + x_off, row_base = win_base + yy*W, addr = row_base + xx.
  always_comb begin
    state_d     = state_q;
    xx_d        = xx_q;
    yy_d        = yy_q;
    x_off_d     = x_off_q;
    y_off_d     = y_off_q;
    addr_d      = addr_q;
    row_base_d  = row_base_q;
    win_base_d  = win_base_q;
    line_base_d = line_base_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_ADDR;
          xx_d        = '0;
          yy_d        = '0;
          x_off_d     = '0;
          y_off_d     = '0;
          addr_d      = '0;
          row_base_d  = '0;
          win_base_d  = '0;
          line_base_d = '0;
        end
      end
      S_ADDR: begin
        if (pix_fire) begin
          if (row_end) begin
            xx_d       = '0;
            yy_d       = yy_q + W_YY'(1);
            addr_d     = row_base_q + ROW_INC;
            row_base_d = row_base_q + ROW_INC;
            if (win_end) begin
              state_d = S_WAIT;
            end
          end else begin
            xx_d   = xx_q + W_XX'(1);
            addr_d = addr_q + W_ADDR'(1);
          end
        end
      end
      S_WAIT: begin
        if (res_valid) begin
          state_d = res_detect ? S_DET : S_NEXT;
        end
      end
      S_DET: begin
        if (det_ready) begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        xx_d = '0;
        yy_d = '0;
        if (x_last && y_last) begin
          state_d = S_DONE;
        end else if (!x_last) begin
          state_d    = S_ADDR;
          x_off_d    = x_off_q + X_STEP;
          win_base_d = win_base_q + X_INC;
          row_base_d = win_base_q + X_INC;
          addr_d     = win_base_q + X_INC;
        end else begin
          state_d     = S_ADDR;
          x_off_d     = '0;
          y_off_d     = y_off_q + Y_STEP;
          line_base_d = line_base_q + Y_INC;
          win_base_d  = line_base_q + Y_INC;
          row_base_d  = line_base_q + Y_INC;
          addr_d      = line_base_q + Y_INC;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      xx_q        <= '0;
      yy_q        <= '0;
      x_off_q     <= '0;
      y_off_q     <= '0;
      addr_q      <= '0;
      row_base_q  <= '0;
      win_base_q  <= '0;
      line_base_q <= '0;
    end else begin
      state_q     <= state_d;
      xx_q        <= xx_d;
      yy_q        <= yy_d;
      x_off_q     <= x_off_d;
      y_off_q     <= y_off_d;
      addr_q      <= addr_d;
      row_base_q  <= row_base_d;
      win_base_q  <= win_base_d;
      line_base_q <= line_base_d;
    end
  end

  // All outputs decode straight from registers, so reset clears them without a clock.
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign addr_valid = (state_q == S_ADDR);
  assign res_ready  = (state_q == S_WAIT);
  assign det_valid  = (state_q == S_DET);
  assign addr_data  = addr_q;
  assign addr_eot   = addr_valid ? {win_end, row_end} : 2'b00;
  assign det_x      = x_off_q;
  assign det_y      = y_off_q;
  assign dbg_state  = state_q;

endmodule
